pipelined_control_unit: RTL

//  Next-generation ID-stage control for the ANTARES pipeline. Decodes Opcode/Funct, resolves branches/jumps in ID,

---
 rtl/pipelined_control_unit_pkg.sv | 52 +++++
 rtl/pipelined_control_unit_muldiv_sequencer.sv | 50 +++++
 rtl/pipelined_control_unit.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/pipelined_control_unit_pkg.sv
// pipelined_control_unit_pkg: opcode/funct codes, ALU and control-word constants, PCSrc codes and
// HI/LO sequencer states shared by the ID-stage control unit.
package pipelined_control_unit_pkg;
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_R2   = 6'h1C;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MFLO = 6'h12;
  localparam logic [5:0] FN_DIV  = 6'h1A;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_MUL  = 6'h02;
  localparam logic [2:0] ALU_NOP = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SLL = 3'd3;
  localparam logic [2:0] ALU_LUI = 3'd4;
  localparam logic [2:0] ALU_SUB = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;
  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_JUMP   = 2'd1;
  localparam logic [1:0] PC_BRANCH = 2'd2;
  localparam logic [1:0] PC_REG    = 2'd3;
  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_e;
  typedef struct packed {
    logic alu_src;
    logic reg_dst;
    logic no_dest;
    logic mem_write;
    logic mem_read;
    logic mem_to_reg;
    logic reg_write;
  } dp_t;
  localparam dp_t DP_NOP    = dp_t'(7'b0000000);
  localparam dp_t DP_RTYPE  = dp_t'(7'b0100001);
  localparam dp_t DP_NODEST = dp_t'(7'b0010000);
  localparam dp_t DP_IMM    = dp_t'(7'b1000001);
  localparam dp_t DP_LOAD   = dp_t'(7'b1000111);
  localparam dp_t DP_STORE  = dp_t'(7'b1011000);
  localparam dp_t DP_LINK   = dp_t'(7'b0000001);
endpackage

// File: rtl/pipelined_control_unit_muldiv_sequencer.sv
// muldiv_sequencer: IDLE/BUSY/DONE counter FSM tracking the HI/LO unit; issues the start pulse
// and the one-cycle HI/LO write strobe at completion.
module muldiv_sequencer
  import pipelined_control_unit_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic clock,
  input  logic reset_n,
  input  logic issue,
  input  logic op_div,
  output logic start,
  output logic hilo_write,
  output logic busy,
  output logic done
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  md_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, lat;
  assign lat = op_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
  assign start = issue & reset_n;
  assign busy = state_q == MD_BUSY;
  assign done = state_q == MD_DONE;
  assign hilo_write = done;
  // A start in DONE reloads the counter, giving back-to-back issue.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (start) begin
      state_d = (lat == ONE) ? MD_DONE : MD_BUSY;
      cnt_d = lat - ONE;
    end else if (busy) begin
      state_d = (cnt_q == ONE) ? MD_DONE : MD_BUSY;
      cnt_d = cnt_q - ONE;
    end else if (done) begin
      state_d = MD_IDLE;
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= MD_IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: ID-stage decode, branch/jump resolution, ID/EX control register and HI/LO stall.
// Optional CTRL_ILLEGAL_TRAP_EN: unknown encodings raise Illegal and redirect to the jump target.
module pipelined_control_unit
  import pipelined_control_unit_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6,
  parameter int ALUCTRL_W  = 3
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [5:0]           Opcode,
  input  logic [5:0]           Funct,
  input  logic                 Cmp_RsRt,
  input  logic                 Hazard_Stall,
  output logic                 PC_Write,
  output logic                 IFID_Write,
  output logic                 IF_Flush,
  output logic [1:0]           PCSrc,
  output logic                 SignExt,
  output logic                 MulDiv_Start,
  output logic                 MulDiv_Op,
  output logic                 HiLo_Write,
  output logic [ALUCTRL_W-1:0] EX_ALUCtrl,
  output logic                 EX_ALUSrc,
  output logic                 EX_RegDst,
  output logic                 EX_NoDest,
  output logic                 EX_MemWrite,
  output logic                 EX_MemRead,
  output logic                 EX_MemtoReg,
  output logic                 EX_RegWrite,
  output logic                 Illegal
);
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  localparam logic [ALUCTRL_W-1:0] A_NOP = ALUCTRL_W'(ALU_NOP);
  localparam logic [ALUCTRL_W-1:0] A_OR  = ALUCTRL_W'(ALU_OR);
  localparam logic [ALUCTRL_W-1:0] A_ADD = ALUCTRL_W'(ALU_ADD);
  localparam logic [ALUCTRL_W-1:0] A_SLL = ALUCTRL_W'(ALU_SLL);
  localparam logic [ALUCTRL_W-1:0] A_LUI = ALUCTRL_W'(ALU_LUI);
  localparam logic [ALUCTRL_W-1:0] A_SUB = ALUCTRL_W'(ALU_SUB);
  localparam logic [ALUCTRL_W-1:0] A_SLT = ALUCTRL_W'(ALU_SLT);
  logic [ALUCTRL_W-1:0] alu, ex_alu_q, ex_alu_d;
  dp_t dp, ex_dp_q, ex_dp_d;
  logic illegal_q, illegal_d;
  logic is_beq, is_bne, is_j, is_jr, is_md, is_div, is_mf, known;
  logic md_busy, md_done, hilo_stall, stall, taken, trap;
  always_comb begin
    alu = A_NOP;
    dp = DP_NOP;
    is_beq = 1'b0;
    is_bne = 1'b0;
    is_j = 1'b0;
    is_jr = 1'b0;
    is_md = 1'b0;
    is_div = 1'b0;
    is_mf = 1'b0;
    known = 1'b1;
    case (Opcode)
      OP_R:
        case (Funct)
          FN_ADD: begin alu = A_ADD; dp = DP_RTYPE; end
          FN_SUB: begin alu = A_SUB; dp = DP_RTYPE; end
          FN_SLL: begin alu = A_SLL; dp = DP_RTYPE; end
          FN_SLT: begin alu = A_SLT; dp = DP_RTYPE; end
          FN_MFHI, FN_MFLO: begin dp = DP_RTYPE; is_mf = 1'b1; end
          FN_DIV: begin dp = DP_NODEST; is_md = 1'b1; is_div = 1'b1; end
          FN_JR: begin dp = DP_NODEST; is_jr = 1'b1; end
          default: known = 1'b0;
        endcase
      OP_R2:
        if (Funct == FN_MUL) begin
          dp = DP_NODEST;
          is_md = 1'b1;
        end else begin
          known = 1'b0;
        end
      OP_ADDI: begin alu = A_ADD; dp = DP_IMM; end
      OP_LUI: begin alu = A_LUI; dp = DP_IMM; end
      OP_ORI: begin alu = A_OR; dp = DP_IMM; end
      OP_BEQ: begin alu = A_SUB; dp = DP_NODEST; is_beq = 1'b1; end
      OP_BNE: begin alu = A_SUB; dp = DP_NODEST; is_bne = 1'b1; end
      OP_J: begin dp = DP_NODEST; is_j = 1'b1; end
      OP_JAL: begin alu = A_ADD; dp = DP_LINK; is_j = 1'b1; end
      OP_LW: begin alu = A_ADD; dp = DP_LOAD; end
      OP_SW: begin alu = A_ADD; dp = DP_STORE; end
      default: known = 1'b0;
    endcase
  end
  // MFHI/MFLO must also wait through DONE: HI/LO is only written at the end of that cycle.
  assign hilo_stall = ((is_mf | is_md) & md_busy) | (is_mf & md_done);
  assign stall = Hazard_Stall | hilo_stall;
  assign taken = (is_beq & Cmp_RsRt) | (is_bne & ~Cmp_RsRt);
  assign trap = TRAP_EN & ~known;
  assign PC_Write = ~stall;
  assign IFID_Write = ~stall;
  assign IF_Flush = ~stall & (taken | is_j | is_jr | trap);
  assign PCSrc = stall ? PC_SEQ : is_jr ? PC_REG : (is_j | trap) ? PC_JUMP : taken ? PC_BRANCH : PC_SEQ;
  assign SignExt = ~(Opcode == OP_ORI || Opcode == OP_LUI);
  assign MulDiv_Op = is_div;
  muldiv_sequencer #(
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES),
    .CNT_W(CNT_W)
  ) u_seq (
    .clock(clock),
    .reset_n(reset_n),
    .issue(is_md & ~stall),
    .op_div(is_div),
    .start(MulDiv_Start),
    .hilo_write(HiLo_Write),
    .busy(md_busy),
    .done(md_done)
  );
  always_comb begin
    ex_alu_d = stall ? A_NOP : alu;
    ex_dp_d = stall ? DP_NOP : dp;
    illegal_d = trap & ~stall;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ex_alu_q <= A_NOP;
      ex_dp_q <= DP_NOP;
      illegal_q <= 1'b0;
    end else begin
      ex_alu_q <= ex_alu_d;
      ex_dp_q <= ex_dp_d;
      illegal_q <= illegal_d;
    end
  end
  assign EX_ALUCtrl = ex_alu_q;
  assign EX_ALUSrc = ex_dp_q.alu_src;
  assign EX_RegDst = ex_dp_q.reg_dst;
  assign EX_NoDest = ex_dp_q.no_dest;
  assign EX_MemWrite = ex_dp_q.mem_write;
  assign EX_MemRead = ex_dp_q.mem_read;
  assign EX_MemtoReg = ex_dp_q.mem_to_reg;
  assign EX_RegWrite = ex_dp_q.reg_write;
  assign Illegal = illegal_q;
endmodule
